// File: rtl/seq_lock_pkg.sv
// Shared types and defaults for the serial pattern lock detector.
// Holds the FSM state enum and counter width helper.
package seq_lock_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    localparam int          DEF_PAT_LEN = 6;
    localparam logic [5:0]  DEF_PATTERN = 6'b001011;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_window_match.sv
// Serial shift window with fill tracking and combinational hit.
// Reset zeros never complete a pattern thanks to the fill gate.
module seq_window_match
    import seq_lock_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    output logic hit
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
    localparam logic [FW-1:0] FILL_HIT = FW'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] sr_q, sr_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [PAT_LEN-1:0] window;

    // Window as it would look after shifting in the current bit.
    always_comb begin
        window = {sr_q, din};
        hit    = din_valid && (fill_q >= FILL_HIT)
                 && (window == PATTERN);
        sr_d   = sr_q;
        fill_d = fill_q;
        if (din_valid) begin
            sr_d = window[PAT_LEN-2:0];
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Window and fill registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_lock_detector.sv
// Pattern detector with hit counter and frame-lock FSM.
// Lock needs LOCK_N hits spaced exactly PAT_LEN valid bits.
module seq_lock_detector
    import seq_lock_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 LOCK_N  = 3,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             locked,
    output logic             err
);

    localparam int PH_W   = idx_w(PAT_LEN);
    localparam int GOOD_W = idx_w(LOCK_N);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PAT_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);

    lock_state_e       state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              match_q, match_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic              hit;
    logic              boundary;

    seq_window_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_win (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .hit       (hit)
    );

    // Next state, spacing counters, hit counter and pulses.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        good_d   = good_q;
        err_d    = 1'b0;
        match_d  = hit;
        cnt_d    = cnt_q;
        boundary = din_valid && (ph_q == PH_LAST);
        if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        unique case (state_q)
            HUNT: begin
                if (hit) begin
                    state_d = VERIFY;
                    good_d  = GOOD_W'(1);
                    ph_d    = '0;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    ph_d = '0;
                    if (hit) begin
                        if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        state_d = HUNT;
                        good_d  = '0;
                    end
                end else if (din_valid) begin
                    ph_d = ph_q + 1'b1;
                end
            end
            LOCKED: begin
                if (boundary) begin
                    ph_d = '0;
                    if (!hit) begin
                        state_d = HUNT;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end else if (din_valid) begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
                ph_d    = '0;
                good_d  = '0;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= HUNT;
            ph_q     <= '0;
            good_q   <= '0;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            good_q   <= good_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign locked    = locked_q;
    assign err       = err_q;

endmodule
